// File: rtl/branch_redirect_ctrl.sv
// Turns execute-stage branch resolution into a held fetch redirect, a one-cycle flush of
// younger stages, a wrong-path squash window, predictor updates and saturating counters.
module branch_redirect_ctrl #(
  parameter int SHADOW_CYCLES = 2,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ex_br_valid,
  input  logic [31:0]      ex_br_pc,
  input  logic             ex_br_taken,
  input  logic [31:0]      ex_br_target,
  input  logic             ex_pred_taken,
  input  logic [31:0]      ex_pred_target,
  input  logic             fetch_redirect_ready,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             flush,
  output logic             wrong_path,
  output logic             upd_valid,
  output logic [31:0]      upd_pc,
  output logic             upd_taken,
  output logic [31:0]      upd_target,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  typedef enum logic [1:0] {IDLE, HOLD, SHADOW} state_t;

  typedef struct packed {
    logic        vld;
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
  } upd_t;

  state_t           state_q, state_d;
  logic [3:0]       shadow_cnt_q, shadow_cnt_d;
  logic             redirect_valid_q, redirect_valid_d;
  logic [31:0]      redirect_pc_q, redirect_pc_d;
  logic             flush_q, flush_d;
  upd_t             upd_q, upd_d;
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

  logic accept, mispred;

  // Only branches seen while IDLE are on the correct path; everything else is squashed.
  assign accept  = ex_br_valid && (state_q == IDLE);
  assign mispred = (ex_br_taken != ex_pred_taken) || (ex_br_target != ex_pred_target);

  always_comb begin
    state_d          = state_q;
    shadow_cnt_d     = shadow_cnt_q;
    redirect_valid_d = redirect_valid_q;
    redirect_pc_d    = redirect_pc_q;
    flush_d          = 1'b0;
    br_cnt_d         = br_cnt_q;
    mispred_cnt_d    = mispred_cnt_q;

    upd_d        = '0;
    upd_d.vld    = accept;
    upd_d.pc     = accept ? ex_br_pc     : upd_q.pc;
    upd_d.taken  = accept ? ex_br_taken  : upd_q.taken;
    upd_d.target = accept ? ex_br_target : upd_q.target;

    if (accept && (br_cnt_q != '1))
      br_cnt_d = br_cnt_q + CNT_W'(1);

    unique case (state_q)
      IDLE: begin
        if (accept && mispred) begin
          state_d          = HOLD;
          redirect_valid_d = 1'b1;
          redirect_pc_d    = ex_br_target;
          flush_d          = 1'b1;
          if (mispred_cnt_q != '1)
            mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
        end
      end
      HOLD: begin
        if (fetch_redirect_ready) begin
          redirect_valid_d = 1'b0;
          if (SHADOW_CYCLES == 0) begin
            state_d = IDLE;
          end else begin
            state_d      = SHADOW;
            shadow_cnt_d = 4'(SHADOW_CYCLES);
          end
        end
      end
      SHADOW: begin
        shadow_cnt_d = shadow_cnt_q - 4'd1;
        if (shadow_cnt_q <= 4'd1) begin
          state_d      = IDLE;
          shadow_cnt_d = 4'd0;
        end
      end
      default: begin
        state_d          = IDLE;
        shadow_cnt_d     = 4'd0;
        redirect_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= IDLE;
      shadow_cnt_q     <= 4'd0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= 32'd0;
      flush_q          <= 1'b0;
      upd_q            <= '0;
      br_cnt_q         <= '0;
      mispred_cnt_q    <= '0;
    end else begin
      state_q          <= state_d;
      shadow_cnt_q     <= shadow_cnt_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      flush_q          <= flush_d;
      upd_q            <= upd_d;
      br_cnt_q         <= br_cnt_d;
      mispred_cnt_q    <= mispred_cnt_d;
    end
  end

  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign flush          = flush_q;
  assign wrong_path     = (state_q == HOLD) || (state_q == SHADOW);
  assign upd_valid      = upd_q.vld;
  assign upd_pc         = upd_q.pc;
  assign upd_taken      = upd_q.taken;
  assign upd_target     = upd_q.target;
  assign br_cnt         = br_cnt_q;
  assign mispred_cnt    = mispred_cnt_q;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed bench: main instance (SHADOW_CYCLES=2, CNT_W=32) plus a narrow
// instance (SHADOW_CYCLES=0, CNT_W=4) for the no-shadow path and saturation.
module tb_branch_redirect_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_br_valid, ex_br_valid1;
  logic [31:0] ex_br_pc, ex_br_target, ex_pred_target;
  logic        ex_br_taken, ex_pred_taken;
  logic        fetch_redirect_ready;

  logic        redirect_valid, flush, wrong_path, upd_valid, upd_taken;
  logic [31:0] redirect_pc, upd_pc, upd_target, br_cnt, mispred_cnt;

  logic        redirect_valid1, flush1, wrong_path1, upd_valid1, upd_taken1;
  logic [31:0] redirect_pc1, upd_pc1, upd_target1;
  logic [3:0]  br_cnt1, mispred_cnt1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_redirect_ctrl #(.SHADOW_CYCLES(2), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .ex_br_valid(ex_br_valid), .ex_br_pc(ex_br_pc),
    .ex_br_taken(ex_br_taken), .ex_br_target(ex_br_target), .ex_pred_taken(ex_pred_taken),
    .ex_pred_target(ex_pred_target), .fetch_redirect_ready(fetch_redirect_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush),
    .wrong_path(wrong_path), .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .br_cnt(br_cnt), .mispred_cnt(mispred_cnt)
  );

  branch_redirect_ctrl #(.SHADOW_CYCLES(0), .CNT_W(4)) dut1 (
    .clk(clk), .reset(reset), .ex_br_valid(ex_br_valid1), .ex_br_pc(ex_br_pc),
    .ex_br_taken(ex_br_taken), .ex_br_target(ex_br_target), .ex_pred_taken(ex_pred_taken),
    .ex_pred_target(ex_pred_target), .fetch_redirect_ready(fetch_redirect_ready),
    .redirect_valid(redirect_valid1), .redirect_pc(redirect_pc1), .flush(flush1),
    .wrong_path(wrong_path1), .upd_valid(upd_valid1), .upd_pc(upd_pc1), .upd_taken(upd_taken1),
    .upd_target(upd_target1), .br_cnt(br_cnt1), .mispred_cnt(mispred_cnt1)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Outputs observed after tick reflect the edge just taken; inputs set after tick
  // are sampled at the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic br(input logic v, input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                    input logic ptk, input logic [31:0] ptgt);
    ex_br_valid = v; ex_br_pc = pc; ex_br_taken = tk; ex_br_target = tgt;
    ex_pred_taken = ptk; ex_pred_target = ptgt;
  endtask

  initial begin
    reset = 1'b1; ex_br_valid1 = 1'b0; fetch_redirect_ready = 1'b0;
    br(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    chk("rst_rv", redirect_valid, 0); chk("rst_rpc", redirect_pc, 0);
    chk("rst_flush", flush, 0);       chk("rst_wp", wrong_path, 0);
    chk("rst_upd", upd_valid, 0);     chk("rst_updpc", upd_pc, 0);
    chk("rst_br", br_cnt, 0);         chk("rst_mp", mispred_cnt, 0);
    tick(); tick();
    reset = 1'b0;
    tick();

    // Correct prediction
    br(1'b1, 32'h1000, 1'b1, 32'h2000, 1'b1, 32'h2000);
    tick();
    br(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("ok_upd", upd_valid, 1);      chk("ok_updpc", upd_pc, 32'h1000);
    chk("ok_updtk", upd_taken, 1);    chk("ok_updtgt", upd_target, 32'h2000);
    chk("ok_rv", redirect_valid, 0);  chk("ok_wp", wrong_path, 0);
    chk("ok_br", br_cnt, 1);          chk("ok_mp", mispred_cnt, 0);
    tick();
    chk("ok_upd_pulse", upd_valid, 0);

    // Back-to-back correct branches: one update per cycle
    br(1'b1, 32'h1100, 1'b0, 32'h1104, 1'b0, 32'h1104);
    tick();
    br(1'b1, 32'h1104, 1'b1, 32'h1800, 1'b1, 32'h1800);
    chk("b2b_upd0", upd_valid, 1); chk("b2b_pc0", upd_pc, 32'h1100);
    tick();
    br(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("b2b_upd1", upd_valid, 1); chk("b2b_pc1", upd_pc, 32'h1104);
    chk("b2b_br", br_cnt, 3);

    // Direction mispredict, fetch ready in first HOLD cycle
    br(1'b1, 32'h1000, 1'b0, 32'h1004, 1'b1, 32'h2000);
    tick();
    br(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    fetch_redirect_ready = 1'b1;
    chk("dir_rv", redirect_valid, 1); chk("dir_rpc", redirect_pc, 32'h1004);
    chk("dir_flush", flush, 1);       chk("dir_wp1", wrong_path, 1);
    chk("dir_upd", upd_valid, 1);     chk("dir_updtk", upd_taken, 0);
    chk("dir_br", br_cnt, 4);         chk("dir_mp", mispred_cnt, 1);
    tick();
    fetch_redirect_ready = 1'b0;
    chk("dir_rv_drop", redirect_valid, 0); chk("dir_flush_drop", flush, 0);
    chk("dir_wp2", wrong_path, 1);
    tick();
    chk("dir_wp3", wrong_path, 1);
    tick();
    chk("dir_wp4_idle", wrong_path, 0);

    // Target mispredict with stalled fetch, plus wrong-path branch in HOLD
    br(1'b1, 32'h1200, 1'b1, 32'h3000, 1'b1, 32'h2000);
    tick();
    br(1'b1, 32'h1300, 1'b0, 32'h5000, 1'b1, 32'h6000);
    chk("tgt_rv", redirect_valid, 1); chk("tgt_rpc", redirect_pc, 32'h3000);
    chk("tgt_flush", flush, 1);       chk("tgt_mp", mispred_cnt, 2);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_rv", redirect_valid, 1); chk("hold_rpc", redirect_pc, 32'h3000);
      chk("hold_flush", flush, 0);       chk("hold_wp", wrong_path, 1);
      chk("hold_upd", upd_valid, 0);
      chk("hold_br", br_cnt, 5);         chk("hold_mp", mispred_cnt, 2);
    end
    fetch_redirect_ready = 1'b1;
    tick();
    fetch_redirect_ready = 1'b0;
    chk("acc_rv", redirect_valid, 0); chk("acc_wp", wrong_path, 1);
    tick();
    // Branch on the SHADOW->IDLE edge cycle is still wrong-path
    chk("shd_wp", wrong_path, 1); chk("shd_upd", upd_valid, 0);
    br(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    chk("shd_idle", wrong_path, 0); chk("shd_upd2", upd_valid, 0);
    chk("shd_br", br_cnt, 5);       chk("shd_mp", mispred_cnt, 2);
    chk("shd_rpc", redirect_pc, 32'h3000);

    // Asynchronous reset while holding a redirect
    br(1'b1, 32'h1400, 1'b1, 32'h7000, 1'b0, 32'h1404);
    tick();
    br(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("pre_rst_rv", redirect_valid, 1);
    #2 reset = 1'b1;
    #1;
    chk("arst_rv", redirect_valid, 0); chk("arst_wp", wrong_path, 0);
    chk("arst_br", br_cnt, 0);         chk("arst_mp", mispred_cnt, 0);
    chk("arst_rpc", redirect_pc, 0);
    tick();
    reset = 1'b0;
    tick();
    br(1'b1, 32'h1500, 1'b1, 32'h8000, 1'b1, 32'h8000);
    tick();
    br(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("post_upd", upd_valid, 1); chk("post_tgt", upd_target, 32'h8000);
    chk("post_br", br_cnt, 1);     chk("post_rv", redirect_valid, 0);

    // SHADOW_CYCLES=0 instance: HOLD goes straight back to IDLE
    br(1'b0, 32'h1600, 1'b1, 32'h9000, 1'b0, 32'h1604);
    fetch_redirect_ready = 1'b1;
    ex_br_valid1 = 1'b1;
    tick();
    ex_br_valid1 = 1'b0;
    chk("z_rv", redirect_valid1, 1); chk("z_wp", wrong_path1, 1);
    chk("z_rpc", redirect_pc1, 32'h9000);
    tick();
    chk("z_idle", wrong_path1, 0); chk("z_rv_drop", redirect_valid1, 0);
    chk("z_mp", mispred_cnt1, 1);

    // Saturation: 19 more accepted mispredicts (one every two cycles)
    ex_br_valid1 = 1'b1;
    for (int i = 0; i < 38; i++) tick();
    ex_br_valid1 = 1'b0;
    tick(); tick();
    chk("sat_mp", mispred_cnt1, 15); chk("sat_br", br_cnt1, 15);
    chk("sat_main_idle", upd_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_redirect_ctrl.md
# branch_redirect_ctrl

Sequences the resolved output of the execute-stage branch unit into a front-end redirect. Compares the resolved direction/target against the fetch-time prediction, raises a held redirect request to fetch, pulses a flush of younger stages, and marks wrong-path instructions while the front end drains. Also emits a one-cycle predictor update per correct-path branch and keeps saturating branch/mispredict counters.

## Interface
Parameters:
- SHADOW_CYCLES, 2: cycles after redirect acceptance during which instructions still reaching EX are wrong-path (0..15).
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- ex_br_valid  in  1  EX holds a branch/jump with valid resolution this cycle.
- ex_br_pc  in  32  PC of that branch.
- ex_br_taken  in  1  resolved direction (jumps resolve taken).
- ex_br_target  in  32  resolved next PC (taken target or pc+4).
- ex_pred_taken  in  1  direction predicted at fetch.
- ex_pred_target  in  32  next PC predicted at fetch.
- fetch_redirect_ready  in  1  fetch accepts the redirect this cycle.
- redirect_valid  out  1  redirect request, held until accepted.
- redirect_pc  out  32  PC fetch must restart from.
- flush  out  1  one-cycle pulse: kill IF/ID contents.
- wrong_path  out  1  instruction in EX this cycle must be squashed.
- upd_valid, upd_pc[32], upd_taken, upd_target[32]  out  predictor update, one-cycle pulse.
- br_cnt  out  CNT_W  accepted branches, saturating.
- mispred_cnt  out  CNT_W  mispredicts, saturating.

## Operation
- States: IDLE, HOLD, SHADOW. Reset -> IDLE.
- Accepted branch: ex_br_valid && state==IDLE. Branches arriving in HOLD/SHADOW are wrong-path: no update, no count, no redirect.
- Mispredict = (ex_br_taken != ex_pred_taken) || (ex_br_target != ex_pred_target). Target comparison applies in both directions (not-taken target is pc+4).
- Accepted branch in cycle T: upd_* registered, upd_valid=1 at T+1; br_cnt increments.
- Accepted mispredict in cycle T: at T+1 state=HOLD, redirect_valid=1, redirect_pc=ex_br_target (captured at T), flush=1 for exactly one cycle, mispred_cnt increments.
- HOLD: redirect_valid and redirect_pc stable until an edge where fetch_redirect_ready=1. On that edge: SHADOW_CYCLES==0 -> IDLE, else SHADOW with counter=SHADOW_CYCLES.
- SHADOW: counter decrements each cycle; at counter==1 transitions to IDLE next edge (SHADOW lasts exactly SHADOW_CYCLES cycles).
- wrong_path = (state==HOLD) || (state==SHADOW). Combinational from state only.
- fetch_redirect_ready while redirect_valid=0: ignored.
- Counters saturate at all-ones; no wrap.

## Timing
- Reset values: redirect_valid=0, redirect_pc=0, flush=0, wrong_path=0, upd_valid=0, upd_pc=0, upd_taken=0, upd_target=0, br_cnt=0, mispred_cnt=0, state IDLE, shadow counter 0.
- Detection-to-redirect latency: 1 cycle (registered outputs). Ready sampled same cycle redirect_valid first rises is honoured (minimum HOLD length 1 cycle).
- No combinational path from ex_* or fetch_redirect_ready to any output.
- Reset asserted mid-HOLD/SHADOW: immediate return to IDLE, redirect dropped, counters cleared.
- Back-to-back correct branches in IDLE: one upd_valid pulse per cycle, no bubbles.
- Branch in the same cycle as HOLD->IDLE/SHADOW->IDLE transition edge: still wrong-path (state in that cycle not IDLE).

## Test plan
- Correct predict: ex_br_valid=1, pc=0x1000, taken=1, target=0x2000, pred 1/0x2000 -> T+1 upd_valid=1 upd_target=0x2000, redirect_valid=0, br_cnt=1, mispred_cnt=0.
- Direction mispredict, immediate ready: pc=0x1000, taken=0, target=0x1004, pred_taken=1 -> T+1 redirect_valid=1 redirect_pc=0x1004 flush=1; ready=1 at T+1 -> wrong_path=1 for T+1..T+3 (SHADOW_CYCLES=2), IDLE at T+4.
- Target mispredict with stalled fetch: taken/pred both 1, target 0x3000 vs 0x2000, ready held 0 for 5 cycles -> redirect_valid/pc=0x3000 stable 5+ cycles, flush only one cycle.
- Wrong-path branch during HOLD/SHADOW: second mispredicting ex_br_valid -> no upd_valid, counters unchanged, redirect_pc unchanged.
- Reset asserted in HOLD -> redirect_valid=0, wrong_path=0, counters 0 asynchronously; next branch handled normally.
- Saturation: preload-equivalent run with CNT_W=4, 20 mispredicts -> mispred_cnt=15, br_cnt=15.
